// File: rtl/sher_vii_control.sv
// S.H.E.R. VII multi-cycle control FSM.
// Sequences the memory-memory datapath through Fetch/decode/execute states.
// Memory states handshake with the arbiter through MEM_REQ/MEM_READY.
// A per-state wait-state timeout traps to Trap with CAUSE=2.
// Illegal opcodes trap with CAUSE=1, and HALT_CODE parks the FSM in Halt.
// State advances on the falling clock edge.
module sher_vii_control #(
  parameter int unsigned OPCODE_W  = 5,
  parameter logic [4:0]  HALT_CODE = 5'b01101,
  parameter int unsigned WAIT_MAX  = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] code,
  input  logic                MEM_READY,
  input  logic                RESUME,
  output logic                COMMON,
  output logic                SPWRITE,
  output logic                TSPWRITE,
  output logic                WRITEZERO,
  output logic                MEMWRITE,
  output logic                SKIPCMP,
  output logic                GENERIC,
  output logic [1:0]          DATAIN,
  output logic                MEM_REQ,
  output logic [3:0]          current_state,
  output logic                HALTED,
  output logic                TRAP,
  output logic [1:0]          CAUSE,
  output logic [CNT_W-1:0]    INSTR_COUNT
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_MAKE   = 4'd1;
  localparam logic [3:0] S_ADDSP  = 4'd2;
  localparam logic [3:0] S_SUBSP  = 4'd3;
  localparam logic [3:0] S_LOAD   = 4'd4;
  localparam logic [3:0] S_LOGIC  = 4'd5;
  localparam logic [3:0] S_ARI    = 4'd6;
  localparam logic [3:0] S_BRANCH = 4'd7;
  localparam logic [3:0] S_JUMP   = 4'd8;
  localparam logic [3:0] S_HALT   = 4'd9;
  localparam logic [3:0] S_TRAP   = 4'd10;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // The wait counter only needs to reach WAIT_MAX-1: the WAIT_MAX-th stalled
  // cycle is detected while the counter still holds WAIT_MAX-1.
  localparam int unsigned   WW        = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'((WAIT_MAX == 0) ? 0 : (WAIT_MAX - 1));
  localparam logic [WW-1:0] WAIT_SAT  = {WW{1'b1}};
  localparam logic [OPCODE_W-1:0] HALT_EXT = OPCODE_W'(HALT_CODE);

  logic [3:0]       state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_mem;
  logic stall;
  logic timeout;
  logic upper_nz;
  logic is_halt;
  logic illegal;
  logic wr_ok;
  logic common_raw, spwrite_raw, tspwrite_raw, writezero_raw, memwrite_raw;

  // Classify the current state and decode the opcode held in the IR.
  always_comb begin
    is_mem   = (state_q == S_FETCH) || (state_q == S_MAKE) || (state_q == S_LOAD) ||
               (state_q == S_ARI)   || (state_q == S_BRANCH);
    stall    = is_mem && !MEM_READY;
    timeout  = (WAIT_MAX != 0) && stall && (wait_q == WAIT_LAST);
    upper_nz = |(code >> 5);
    is_halt  = (code == HALT_EXT);
    illegal  = upper_nz || ((code[1:0] == 2'b01) && code[3] && !is_halt);
  end

  // Next-state, trap cause, wait counter and retired-instruction counter.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    wait_d  = '0;
    if (timeout) begin
      state_d = S_TRAP;
      cause_d = CAUSE_TIMEOUT;
    end else if (stall) begin
      // Saturate so a disabled timeout never wraps back into a false match.
      wait_d = (wait_q == WAIT_SAT) ? wait_q : wait_q + WW'(1);
    end else begin
      case (state_q)
        S_FETCH: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (illegal) begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end else if (is_halt) begin
            state_d = S_HALT;
          end else begin
            case (code[1:0])
              2'b00:   state_d = S_MAKE;
              2'b01:   state_d = code[2] ? S_SUBSP : S_ADDSP;
              default: state_d = S_LOAD;
            endcase
          end
        end
        S_LOAD: state_d = S_LOGIC;
        S_LOGIC: begin
          if (code[1:0] == 2'b10) begin
            state_d = S_ARI;
          end else if (code[1:0] == 2'b11) begin
            state_d = code[4] ? S_JUMP : S_BRANCH;
          end else begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        end
        S_MAKE, S_ADDSP, S_SUBSP, S_ARI, S_BRANCH, S_JUMP: state_d = S_FETCH;
        S_HALT: begin
          if (RESUME) state_d = S_FETCH;
        end
        S_TRAP: begin
          if (RESUME) begin
            state_d = S_FETCH;
            cause_d = CAUSE_NONE;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Per-state control decode; write enables in memory states wait for MEM_READY.
  always_comb begin
    common_raw    = 1'b0;
    spwrite_raw   = 1'b0;
    tspwrite_raw  = 1'b0;
    writezero_raw = 1'b0;
    memwrite_raw  = 1'b0;
    SKIPCMP       = 1'b0;
    GENERIC       = 1'b0;
    DATAIN        = 2'd0;
    case (state_q)
      S_FETCH: begin
        common_raw = 1'b1;
        SKIPCMP    = 1'b1;
        GENERIC    = 1'b1;
      end
      S_MAKE: begin
        memwrite_raw = 1'b1;
        SKIPCMP      = 1'b1;
        GENERIC      = 1'b1;
      end
      S_ADDSP: begin
        tspwrite_raw = 1'b1;
        GENERIC      = 1'b1;
      end
      S_SUBSP: begin
        spwrite_raw = 1'b1;
        SKIPCMP     = 1'b1;
        GENERIC     = 1'b1;
      end
      S_LOAD: GENERIC = 1'b1;
      S_ARI: begin
        DATAIN       = 2'd1;
        memwrite_raw = 1'b1;
        SKIPCMP      = 1'b1;
      end
      S_BRANCH: begin
        common_raw    = 1'b1;
        DATAIN        = 2'd2;
        spwrite_raw   = 1'b1;
        writezero_raw = 1'b1;
        memwrite_raw  = 1'b1;
      end
      S_JUMP: common_raw = 1'b1;
      default: ;
    endcase
    // Holding reset suppresses every enable so an aborted access never writes.
    wr_ok     = Reset && (!is_mem || MEM_READY);
    COMMON    = common_raw    && wr_ok;
    SPWRITE   = spwrite_raw   && wr_ok;
    TSPWRITE  = tspwrite_raw  && wr_ok;
    WRITEZERO = writezero_raw && wr_ok;
    MEMWRITE  = memwrite_raw  && wr_ok;
    MEM_REQ   = is_mem && Reset;
  end

  // Status outputs come straight from the registers.
  always_comb begin
    current_state = state_q;
    HALTED        = (state_q == S_HALT);
    TRAP          = (state_q == S_TRAP);
    CAUSE         = cause_q;
    INSTR_COUNT   = cnt_q;
  end

  // State registers, updated on the falling edge with asynchronous reset.
  always_ff @(negedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/sher_vii_control.md
Name: sher_vii_control

Overview:
- Parametrised multi-cycle control FSM for the S.H.E.R. VII memory-memory processor.
- Successor to the S.H.E.R. VI controller: same state set and control outputs, plus:
  - variable-latency memory handshake (MEM_REQ/MEM_READY) with a wait-state timeout;
  - configurable opcode width;
  - a HALT instruction and an illegal-opcode/timeout trap;
  - a retired-instruction counter.
- Sits between the instruction register and the datapath/memory arbiter.

Parameters:
- OPCODE_W, 5, opcode width (>=5); bits above [4] must be zero for a legal opcode.
- HALT_CODE, 5'b01101, opcode (zero-extended to OPCODE_W) that enters Halt.
- WAIT_MAX, 8, max wait-state cycles per memory state before trap; 0 disables the timeout.
- CNT_W, 16, width of INSTR_COUNT.

Ports:
- CLK  in  1  system clock; all state updates on falling edge.
- Reset  in  1  asynchronous, active-low reset.
- code  in  OPCODE_W  opcode from IR; stable from Fetch completion until next Fetch.
- MEM_READY  in  1  memory completes current access this cycle.
- RESUME  in  1  leave Halt/Trap.
- COMMON, SPWRITE, TSPWRITE, WRITEZERO, MEMWRITE  out  1 each  write enables.
- SKIPCMP, GENERIC  out  1 each  datapath selects.
- DATAIN  out  2  memory data-in select.
- MEM_REQ  out  1  memory access request.
- current_state  out  4  state encoding (debug).
- HALTED  out  1  in Halt.
- TRAP  out  1  in Trap.
- CAUSE  out  2  trap cause: 0 none, 1 illegal opcode, 2 memory timeout.
- INSTR_COUNT  out  CNT_W  completed Fetches, wraps.

Behaviour:
- Reset=0 (async, immediate):
  - state=Fetch(0); wait counter, CAUSE and INSTR_COUNT = 0.
  - Outputs follow the Fetch decode; MEM_REQ=1 after release.
- State encodings: Fetch0 Make1 AddSP2 SubSP3 Load4 Logic5 Ari6 Branch7 Jump8 Halt9 Trap10; unused encodings go to Fetch next edge.
- Per-state outputs (all others 0):
  - Fetch: COMMON SKIPCMP GENERIC
  - Make: MEMWRITE SKIPCMP GENERIC
  - AddSP: TSPWRITE GENERIC
  - SubSP: SPWRITE SKIPCMP GENERIC
  - Load: GENERIC
  - Logic: none
  - Ari: DATAIN=1, MEMWRITE, SKIPCMP
  - Branch: COMMON, DATAIN=2, SPWRITE, WRITEZERO, MEMWRITE
  - Jump: COMMON
- Memory states (Fetch, Make, Load, Ari, Branch):
  - MEM_REQ=1.
  - Write enables (COMMON, SPWRITE, TSPWRITE, WRITEZERO, MEMWRITE) gated combinationally by MEM_READY.
  - Selects (SKIPCMP, GENERIC, DATAIN) are not gated.
  - State is held while MEM_READY=0.
- Non-memory states (AddSP, SubSP, Logic, Jump) complete in one cycle, ungated.
- Wait counter:
  - Counts each cycle a memory state is held; clears on state change.
  - With WAIT_MAX>0, on the WAIT_MAX-th consecutive not-ready cycle: next state Trap, CAUSE=2.
  - MEM_READY in that same cycle wins; there is no trap.
- Decode at Fetch completion (MEM_READY=1):
  - Illegal if bits [OPCODE_W-1:5] are nonzero, or if class 1 with code[3]=1 and code != HALT_CODE. Illegal -> Trap, CAUSE=1.
  - code==HALT_CODE -> Halt.
  - Otherwise by code[1:0]:
    - 0 -> Make.
    - 1 -> AddSP if code[2]=0, else SubSP.
    - 2 and 3 -> Load.
- Load -> Logic on completion.
- Logic: code[1:0]=2 -> Ari; code[1:0]=3 -> Branch if code[4]=0, else Jump; any other value -> Trap, CAUSE=1.
- Make, AddSP, SubSP, Ari, Branch and Jump return to Fetch on completion.
- INSTR_COUNT increments on every Fetch completion, including those entering Halt or Trap; wraps modulo 2^CNT_W.
- Halt:
  - HALTED=1; all enables and MEM_REQ are 0.
  - RESUME=1 -> Fetch next edge.
- Trap:
  - TRAP=1; CAUSE is held; all enables and MEM_REQ are 0.
  - RESUME=1 -> Fetch, and CAUSE clears to 0.
- RESUME is ignored in all other states.
- Reset asserted mid-wait or mid-instruction aborts immediately with no further enables.

Test Plan:
- Reset low then high, MEM_READY=1, code=5'b00000 -> states 0,1,0; MEMWRITE=1 only in Make; INSTR_COUNT=1 after Fetch.
- code=5'b00011 (Branch), MEM_READY held 0 for 3 cycles in Load -> MEM_REQ=1 and GENERIC=1 throughout; then states 4,5,7,0; WRITEZERO=1 only in the Branch cycle with MEM_READY=1.
- code=5'b10011, MEM_READY=1 -> states 0,4,5,8,0; COMMON=1 in Jump, DATAIN=0.
- code=HALT_CODE -> state 9, HALTED=1, MEM_REQ=0; RESUME pulse -> Fetch next edge; INSTR_COUNT incremented once.
- OPCODE_W=6, code=6'b100000 -> Trap, CAUSE=1; MEM_READY=0 for 8 cycles in Fetch -> Trap, CAUSE=2; MEM_READY=1 on the 8th cycle -> no trap.
- Reset pulled low while stalled in Ari -> immediately state 0, MEMWRITE=0, CAUSE=0, INSTR_COUNT=0.
